duty_ramp_sequencer: RTL and testbench
======================================

// Module: duty_ramp_sequencer
// PURPOSE
//  Upstream stage of the three-phase PWM. Accepts duty commands over a valid/ready handshake and
//  slew-limits the duty word, updating only at PWM period boundaries so each period is glitch-free.
//  Sequences soft-start and soft-stop, and owns the PWM enable. Drives the PWM duty_cycle and en inputs.
// PARAMETERS
//  STEP            4    max duty change per applied step (1..255)
//  TICKS_PER_STEP  1    period_tick pulses between steps (1..255)
//  DUTY_MIN        0    lower clamp on accepted commands
//  DUTY_MAX        255  upper clamp on accepted commands (>= DUTY_MIN)
// PORTS
//  clk          in   1  system clock, all logic on rising edge
//  rst_n        in   1  asynchronous active-low reset
//  period_tick  in   1  one-cycle pulse at PWM counter wrap (count 255->0)
//  en_req       in   1  level; 1 = run, 0 = ramp down then stop
//  cmd_valid    in   1  duty command valid
//  cmd_ready    out  1  command accepted when cmd_valid & cmd_ready
//  cmd_duty     in   8  requested duty
//  duty_cycle   out  8  slewed duty to PWM, registered
//  pwm_en       out  1  PWM enable, registered
//  at_target    out  1  duty_cycle == effective target
//  ramp_busy    out  1  state != IDLE and !at_target
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, duty_cycle=0, pwm_en=0, target_reg=0, tick_cnt=0.
//   Reset mid-ramp aborts immediately to these values.
//  States: IDLE, RUN, STOP. pwm_en=1 in RUN and STOP, 0 in IDLE. Transitions are registered.
//   IDLE -> RUN  : en_req=1. tick_cnt cleared.
//   RUN  -> STOP : en_req=0.
//   STOP -> RUN  : en_req=1. Ramp resumes up from the current duty_cycle.
//   STOP -> IDLE : duty_cycle==0 and en_req=0. Transition occurs the cycle after duty_cycle
//                  reaches 0, or on the next cycle if STOP is entered with duty 0.
//  Handshake:
//   - cmd_ready = (state != STOP), decoded from the state register.
//   - On accept: target_reg <= clamp(cmd_duty, DUTY_MIN, DUTY_MAX).
//   - Commands are accepted in IDLE; target_reg is retained across stop/start.
//  Effective target: target_reg in RUN; 0 in STOP and IDLE.
//  Stepping:
//   - tick_cnt counts period_tick pulses only in RUN/STOP.
//   - A step applies on a period_tick with tick_cnt==TICKS_PER_STEP-1; tick_cnt then wraps to 0.
//   - Step: if |target-duty| <= STEP then duty <= target; else duty <= duty +/- STEP.
//   - Step arithmetic uses 9 bits; duty never wraps past 0 or 255.
//   - duty_cycle changes exactly 1 clk after the qualifying period_tick.
//   - No change occurs outside ticks.
//  Simultaneous events:
//   - Command accepted in the same cycle as a step: the step uses the old target_reg.
//   - en_req falls in the same cycle a command is accepted: the command is stored, and STOP ramps to 0.
//   - period_tick in IDLE is ignored.
// TESTING (STEP=4, TICKS_PER_STEP=1 unless noted)
//  1 Reset: rst_n=0 mid-ramp at duty 40 -> same-cycle duty_cycle=0, pwm_en=0, cmd_ready=1.
//  2 Soft-start: cmd 100 in IDLE, en_req=1 -> pwm_en=1 next clk; duty 4,8,..,100 on 25 ticks;
//    at_target=1 after the 25th tick; ramp_busy=0.
//  3 Retarget down: at duty 40 accept cmd 30 -> next ticks 36,32,30. Then cmd 31 -> 31 on one tick.
//  4 Soft-stop: at duty 10 drop en_req -> cmd_ready=0; duty 6,2,0; pwm_en=0 one clk after 0.
//    Re-raise en_req at duty 6 -> RUN; ramp back up toward stored target.
//  5 Clamp/divider: DUTY_MAX=200, TICKS_PER_STEP=3, cmd 250 -> target 200.
//    Duty steps only on every 3rd tick.
//  6 Collision: cmd 20 accepted on the same clk as a step tick at duty 0, target 100 -> duty 4.
//    Next tick -> 8, then 12, 16, 20, then holds.

Source files
------------

// File: rtl/duty_ramp_sequencer.sv
// Slew-limited duty sequencer for the three-phase PWM. It updates the duty only on period
// boundaries, runs the soft-start and soft-stop sequences, and owns the PWM enable.
module duty_ramp_sequencer #(
  parameter int unsigned STEP           = 4,
  parameter int unsigned TICKS_PER_STEP = 1,
  parameter int unsigned DUTY_MIN       = 0,
  parameter int unsigned DUTY_MAX       = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       period_tick,
  input  logic       en_req,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_duty,
  output logic [7:0] duty_cycle,
  output logic       pwm_en,
  output logic       at_target,
  output logic       ramp_busy
);

  localparam logic [8:0] LP_STEP      = 9'(STEP);
  localparam logic [7:0] LP_TICK_LAST = 8'(TICKS_PER_STEP - 1);
  localparam logic [7:0] LP_MIN       = 8'(DUTY_MIN);
  localparam logic [7:0] LP_MAX       = 8'(DUTY_MAX);

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

  state_e     r_state, w_state_next;
  logic [7:0] r_duty, w_duty_next;
  logic [7:0] r_target, w_target_next;
  logic [7:0] r_tick_cnt, w_tick_cnt_next;
  logic       r_pwm_en;
  logic [7:0] w_eff_target;
  logic [7:0] w_cmd_clamped;
  logic [8:0] w_diff;
  logic       w_active;
  logic       w_accept;
  logic       w_step;

  always_comb begin
    w_active     = (r_state != StIdle);
    w_eff_target = (r_state == StRun) ? r_target : 8'd0;
    w_accept     = cmd_valid && (r_state != StStop);
    w_step       = w_active && period_tick && (r_tick_cnt == LP_TICK_LAST);
  end

  always_comb begin
    w_cmd_clamped = cmd_duty;
    if (cmd_duty >= LP_MAX) w_cmd_clamped = LP_MAX;
    if (cmd_duty <= LP_MIN) w_cmd_clamped = LP_MIN;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (en_req) w_state_next = StRun;
      StRun:  if (!en_req) w_state_next = StStop;
      StStop: begin
        if (en_req) w_state_next = StRun;
        else if (r_duty == 8'd0) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_target_next = r_target;
    if (w_accept) w_target_next = w_cmd_clamped;
  end

  always_comb begin
    w_tick_cnt_next = r_tick_cnt;
    if ((r_state == StIdle) && en_req) begin
      w_tick_cnt_next = 8'd0;
    end else if (w_active && period_tick) begin
      w_tick_cnt_next = w_step ? 8'd0 : r_tick_cnt + 8'd1;
    end
  end

  // 9-bit difference so a full step never wraps past 0 or 255; the target bounds the result.
  always_comb begin
    w_duty_next = r_duty;
    w_diff      = 9'd0;
    if (w_step) begin
      if (r_duty < w_eff_target) begin
        w_diff      = {1'b0, w_eff_target} - {1'b0, r_duty};
        w_duty_next = (w_diff <= LP_STEP) ? w_eff_target : 8'({1'b0, r_duty} + LP_STEP);
      end else begin
        w_diff      = {1'b0, r_duty} - {1'b0, w_eff_target};
        w_duty_next = (w_diff <= LP_STEP) ? w_eff_target : 8'({1'b0, r_duty} - LP_STEP);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_duty     <= 8'd0;
      r_target   <= 8'd0;
      r_tick_cnt <= 8'd0;
      r_pwm_en   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_duty     <= w_duty_next;
      r_target   <= w_target_next;
      r_tick_cnt <= w_tick_cnt_next;
      r_pwm_en   <= (w_state_next != StIdle);
    end
  end

  assign cmd_ready  = (r_state != StStop);
  assign duty_cycle = r_duty;
  assign pwm_en     = r_pwm_en;
  assign at_target  = (r_duty == w_eff_target);
  assign ramp_busy  = w_active && !at_target;

endmodule

// File: tb/tb_duty_ramp_sequencer.sv
// Bench for duty_ramp_sequencer: directed stimulus pushes expected duty values into queues and
// monitors pop them whenever the duty output changes.
module tb_duty_ramp_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       period_tick = 1'b0, en_req = 1'b0, cmd_valid = 1'b0;
  logic [7:0] cmd_duty = 8'd0;
  logic       cmd_ready, pwm_en, at_target, ramp_busy;
  logic [7:0] duty_cycle;

  logic       b_tick = 1'b0, b_en_req = 1'b0, b_cmd_valid = 1'b0;
  logic [7:0] b_cmd_duty = 8'd0;
  logic       b_cmd_ready, b_pwm_en, b_at_target, b_ramp_busy;
  logic [7:0] b_duty_cycle;

  int checks = 0;
  int errors = 0;

  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] prev1 = 8'd0;
  logic [7:0] prev2 = 8'd0;

  duty_ramp_sequencer dut (
    .clk(clk), .rst_n(rst_n), .period_tick(period_tick), .en_req(en_req),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_duty(cmd_duty),
    .duty_cycle(duty_cycle), .pwm_en(pwm_en), .at_target(at_target), .ramp_busy(ramp_busy)
  );

  duty_ramp_sequencer #(.STEP(4), .TICKS_PER_STEP(3), .DUTY_MIN(0), .DUTY_MAX(200)) dut2 (
    .clk(clk), .rst_n(rst_n), .period_tick(b_tick), .en_req(b_en_req),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_duty(b_cmd_duty),
    .duty_cycle(b_duty_cycle), .pwm_en(b_pwm_en), .at_target(b_at_target),
    .ramp_busy(b_ramp_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : mon1
    logic [7:0] e;
    if (duty_cycle !== prev1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL sb1_duty got %0d required no change", duty_cycle);
      end else begin
        e = q1.pop_front();
        if (duty_cycle !== e) begin
          errors++;
          $display("FAIL sb1_duty got %0d required %0d", duty_cycle, e);
        end
      end
      prev1 = duty_cycle;
    end
  end

  always @(negedge clk) begin : mon2
    logic [7:0] e;
    if (b_duty_cycle !== prev2) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL sb2_duty got %0d required no change", b_duty_cycle);
      end else begin
        e = q2.pop_front();
        if (b_duty_cycle !== e) begin
          errors++;
          $display("FAIL sb2_duty got %0d required %0d", b_duty_cycle, e);
        end
      end
      prev2 = b_duty_cycle;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    period_tick = 1'b1;
    cyc();
    period_tick = 1'b0;
    cyc();
  endtask

  task automatic tick2();
    b_tick = 1'b1;
    cyc();
    b_tick = 1'b0;
    cyc();
  endtask

  task automatic send(input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_duty  = d;
    cyc();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_duty", duty_cycle, 8'd0);
    chk("rst_pwm_en", {7'd0, pwm_en}, 8'd0);
    chk("rst_ready", {7'd0, cmd_ready}, 8'd1);

    // Reset mid-ramp at duty 40
    send(8'd100);
    en_req = 1'b1;
    cyc();
    for (int i = 1; i <= 10; i++) begin
      q1.push_back(8'(4 * i));
      tick();
    end
    chk("pre_rst_duty", duty_cycle, 8'd40);
    q1.push_back(8'd0);
    en_req = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("midrst_duty", duty_cycle, 8'd0);
    chk("midrst_pwm_en", {7'd0, pwm_en}, 8'd0);
    chk("midrst_ready", {7'd0, cmd_ready}, 8'd1);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Soft-start to 100
    send(8'd100);
    chk("idle_pwm_en", {7'd0, pwm_en}, 8'd0);
    en_req = 1'b1;
    cyc();
    chk("start_pwm_en", {7'd0, pwm_en}, 8'd1);
    chk("start_busy", {7'd0, ramp_busy}, 8'd1);
    for (int i = 1; i <= 25; i++) begin
      q1.push_back(8'(4 * i));
      tick();
    end
    chk("start_duty", duty_cycle, 8'd100);
    chk("start_at_target", {7'd0, at_target}, 8'd1);
    chk("start_busy_done", {7'd0, ramp_busy}, 8'd0);
    tick();
    cyc();

    // Retarget down to 40, then 30, then 31
    send(8'd40);
    for (int i = 1; i <= 15; i++) begin
      q1.push_back(8'(100 - 4 * i));
      tick();
    end
    send(8'd30);
    q1.push_back(8'd36); tick();
    q1.push_back(8'd32); tick();
    q1.push_back(8'd30); tick();
    chk("retarget_30", duty_cycle, 8'd30);
    send(8'd31);
    q1.push_back(8'd31); tick();
    chk("retarget_31", duty_cycle, 8'd31);
    chk("retarget_at_target", {7'd0, at_target}, 8'd1);

    // Down to 10, then soft-stop with a resume at 6
    send(8'd10);
    q1.push_back(8'd27); tick();
    q1.push_back(8'd23); tick();
    q1.push_back(8'd19); tick();
    q1.push_back(8'd15); tick();
    q1.push_back(8'd11); tick();
    q1.push_back(8'd10); tick();
    en_req = 1'b0;
    cyc();
    chk("stop_ready", {7'd0, cmd_ready}, 8'd0);
    chk("stop_pwm_en", {7'd0, pwm_en}, 8'd1);
    chk("stop_busy", {7'd0, ramp_busy}, 8'd1);
    q1.push_back(8'd6); tick();
    en_req = 1'b1;
    cyc();
    chk("resume_ready", {7'd0, cmd_ready}, 8'd1);
    q1.push_back(8'd10); tick();
    chk("resume_duty", duty_cycle, 8'd10);
    en_req = 1'b0;
    cyc();
    q1.push_back(8'd6); tick();
    q1.push_back(8'd2); tick();
    period_tick = 1'b1;
    q1.push_back(8'd0);
    cyc();
    period_tick = 1'b0;
    chk("zero_pwm_en_hold", {7'd0, pwm_en}, 8'd1);
    cyc();
    chk("zero_pwm_en_off", {7'd0, pwm_en}, 8'd0);
    chk("idle_ready", {7'd0, cmd_ready}, 8'd1);
    tick();
    chk("idle_tick_ignored", duty_cycle, 8'd0);

    // Command collides with a step tick: step uses the old target 100
    send(8'd100);
    en_req = 1'b1;
    cyc();
    cmd_valid   = 1'b1;
    cmd_duty    = 8'd20;
    period_tick = 1'b1;
    q1.push_back(8'd4);
    cyc();
    cmd_valid   = 1'b0;
    period_tick = 1'b0;
    cyc();
    chk("collide_duty", duty_cycle, 8'd4);
    for (int i = 2; i <= 5; i++) begin
      q1.push_back(8'(4 * i));
      tick();
    end
    tick();
    chk("collide_hold", duty_cycle, 8'd20);
    chk("collide_at_target", {7'd0, at_target}, 8'd1);

    // en_req falls while a command is accepted: command stored, ramp to 0
    en_req    = 1'b0;
    cmd_valid = 1'b1;
    cmd_duty  = 8'd60;
    cyc();
    cmd_valid = 1'b0;
    chk("fall_cmd_ready", {7'd0, cmd_ready}, 8'd0);
    for (int i = 1; i <= 5; i++) begin
      q1.push_back(8'(20 - 4 * i));
      tick();
    end
    cyc();
    chk("fall_pwm_en", {7'd0, pwm_en}, 8'd0);
    en_req = 1'b1;
    cyc();
    q1.push_back(8'd4); tick();
    chk("fall_stored_busy", {7'd0, ramp_busy}, 8'd1);
    en_req = 1'b0;

    // Clamp and tick divider on the second instance
    b_cmd_valid = 1'b1;
    b_cmd_duty  = 8'd250;
    cyc();
    b_cmd_valid = 1'b0;
    b_en_req    = 1'b1;
    cyc();
    tick2();
    tick2();
    chk("div_no_step", b_duty_cycle, 8'd0);
    for (int i = 1; i <= 50; i++) begin
      if (i > 1) begin
        tick2();
        tick2();
      end
      q2.push_back(8'(4 * i));
      tick2();
    end
    for (int i = 0; i < 3; i++) tick2();
    chk("clamp_duty", b_duty_cycle, 8'd200);
    chk("clamp_at_target", {7'd0, b_at_target}, 8'd1);

    for (int i = 0; i < 4; i++) cyc();
    chk("sb1_drained", 8'(q1.size()), 8'd0);
    chk("sb2_drained", 8'(q2.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
